// File: rtl/vga_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_reader_pkg
// Description : Shared VGA timing defaults, decode types and helpers for the
//               frame buffer scan-out path.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_frame_reader_pkg;

    localparam int c_def_clk_div     = 2;
    localparam int c_def_scale_shift = 2;

    localparam int c_def_h_visible   = 640;
    localparam int c_def_h_front     = 16;
    localparam int c_def_h_sync      = 96;
    localparam int c_def_h_back      = 48;

    localparam int c_def_v_visible   = 480;
    localparam int c_def_v_front     = 10;
    localparam int c_def_v_sync      = 2;
    localparam int c_def_v_back      = 33;

    localparam int c_cnt_w           = 10;

    // Sync levels are already active-low; vis is active-high.
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    function automatic logic in_range(
        input logic [c_cnt_w-1:0] value,
        input logic [c_cnt_w-1:0] lo,
        input logic [c_cnt_w-1:0] hi
    );
        return (value >= lo) && (value < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_reader_timing_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_counter
// Description : Pixel-rate divider, horizontal/vertical counters, sync and
//               visible decode, frame_start pulse and registered vblank flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_counter
    import vga_frame_reader_pkg::*;
#(
    parameter int CLK_DIV   = c_def_clk_div,
    parameter int H_VISIBLE = c_def_h_visible,
    parameter int H_FRONT   = c_def_h_front,
    parameter int H_SYNC    = c_def_h_sync,
    parameter int H_BACK    = c_def_h_back,
    parameter int V_VISIBLE = c_def_v_visible,
    parameter int V_FRONT   = c_def_v_front,
    parameter int V_SYNC    = c_def_v_sync,
    parameter int V_BACK    = c_def_v_back
) (
    input  logic               clk,
    input  logic               reset,
    output logic               o_pix_en,
    output logic [c_cnt_w-1:0] o_h_cnt,
    output logic [c_cnt_w-1:0] o_v_cnt,
    output sync_t              o_dec,
    output logic               o_frame_start,
    output logic               o_in_vblank
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0]   c_div_last  = DIV_W'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_h_visible = c_cnt_w'(H_VISIBLE);
    localparam logic [c_cnt_w-1:0] c_v_visible = c_cnt_w'(V_VISIBLE);
    localparam logic [c_cnt_w-1:0] c_h_last    = c_cnt_w'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [c_cnt_w-1:0] c_v_last    = c_cnt_w'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [c_cnt_w-1:0] c_hs_start  = c_cnt_w'(H_VISIBLE + H_FRONT);
    localparam logic [c_cnt_w-1:0] c_hs_end    = c_cnt_w'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [c_cnt_w-1:0] c_vs_start  = c_cnt_w'(V_VISIBLE + V_FRONT);
    localparam logic [c_cnt_w-1:0] c_vs_end    = c_cnt_w'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]   r_div_cnt;
    logic [c_cnt_w-1:0] r_h_cnt;
    logic [c_cnt_w-1:0] r_v_cnt;
    logic               r_frame_start;
    logic               r_in_vblank;

    logic               w_h_last;
    logic               w_v_last;
    logic [c_cnt_w-1:0] w_h_next;
    logic [c_cnt_w-1:0] w_v_next;

    assign o_pix_en = (r_div_cnt == c_div_last);
    assign w_h_last = (r_h_cnt == c_h_last);
    assign w_v_last = (r_v_cnt == c_v_last);
    assign w_h_next = w_h_last ? '0 : r_h_cnt + 10'd1;
    assign w_v_next = !w_h_last ? r_v_cnt : (w_v_last ? '0 : r_v_cnt + 10'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
            r_in_vblank   <= 1'b0;
        end else begin
            r_div_cnt     <= o_pix_en ? '0 : r_div_cnt + 1'b1;
            r_frame_start <= 1'b0;
            if (o_pix_en) begin
                r_h_cnt       <= w_h_next;
                r_v_cnt       <= w_v_next;
                r_frame_start <= w_h_last && w_v_last;
                // Decoded from the post-increment row so the flag rises with v_cnt reaching V_VISIBLE.
                r_in_vblank   <= (w_v_next >= c_v_visible);
            end
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_frame_start = r_frame_start;
    assign o_in_vblank   = r_in_vblank;

    assign o_dec.hs  = !in_range(r_h_cnt, c_hs_start, c_hs_end);
    assign o_dec.vs  = !in_range(r_v_cnt, c_vs_start, c_vs_end);
    assign o_dec.vis = (r_h_cnt < c_h_visible) && (r_v_cnt < c_v_visible);

endmodule
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_reader
// Description : Frame buffer scan-out: VGA timing, buffer read addressing and
//               two-stage colour/sync pipeline towards the VGA DAC.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int CLK_DIV     = c_def_clk_div,
    parameter int SCALE_SHIFT = c_def_scale_shift,
    parameter int H_VISIBLE   = c_def_h_visible,
    parameter int H_FRONT     = c_def_h_front,
    parameter int H_SYNC      = c_def_h_sync,
    parameter int H_BACK      = c_def_h_back,
    parameter int V_VISIBLE   = c_def_v_visible,
    parameter int V_FRONT     = c_def_v_front,
    parameter int V_SYNC      = c_def_v_sync,
    parameter int V_BACK      = c_def_v_back
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] x_read,
    output logic [6:0] y_read,
    input  logic [2:0] color_out,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       frame_start,
    output logic       in_vblank
);

    logic               w_pix_en;
    logic [c_cnt_w-1:0] w_h_cnt;
    logic [c_cnt_w-1:0] w_v_cnt;
    sync_t              w_dec;
    sync_t              r_dec_a;

    vga_timing_counter #(
        .CLK_DIV   (CLK_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk           (clk),
        .reset         (reset),
        .o_pix_en      (w_pix_en),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_dec         (w_dec),
        .o_frame_start (frame_start),
        .o_in_vblank   (in_vblank)
    );

    // Stage A: issue the buffer address; the RAM answers before the next pixel tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_read  <= '0;
            y_read  <= '0;
            r_dec_a <= '{hs: 1'b1, vs: 1'b1, vis: 1'b0};
        end else if (w_pix_en) begin
            x_read  <= w_dec.vis ? 8'(w_h_cnt >> SCALE_SHIFT) : 8'd0;
            y_read  <= w_dec.vis ? 7'(w_v_cnt >> SCALE_SHIFT) : 7'd0;
            r_dec_a <= w_dec;
        end
    end

    // Stage B: colour and sync leave together, two pixel ticks behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (w_pix_en) begin
            vga_r       <= r_dec_a.vis ? {8{color_out[2]}} : 8'h00;
            vga_g       <= r_dec_a.vis ? {8{color_out[1]}} : 8'h00;
            vga_b       <= r_dec_a.vis ? {8{color_out[0]}} : 8'h00;
            vga_hs      <= r_dec_a.hs;
            vga_vs      <= r_dec_a.vs;
            vga_blank_n <= r_dec_a.vis;
        end
    end

    assign vga_sync_n = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_reader
// Description : Scoreboard bench for vga_frame_reader with a reduced raster,
//               random buffer contents and random mid-frame resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;

    localparam int CD  = 2;
    localparam int SS  = 2;
    localparam int HV  = 32;
    localparam int HF  = 4;
    localparam int HSY = 8;
    localparam int HB  = 4;
    localparam int VV  = 16;
    localparam int VF  = 2;
    localparam int VSY = 2;
    localparam int VB  = 3;
    localparam int HT  = HV + HF + HSY + HB;
    localparam int VT  = VV + VF + VSY + VB;
    localparam int FT  = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x_read;
    logic [6:0] y_read;
    logic [2:0] color_out;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, in_vblank;

    vga_frame_reader #(
        .CLK_DIV(CD), .SCALE_SHIFT(SS),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .x_read(x_read), .y_read(y_read),
        .color_out(color_out), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .frame_start(frame_start), .in_vblank(in_vblank)
    );

    always #5 clk = ~clk;

    // Frame buffer with one-clock read latency.
    logic [2:0] mem [0:127][0:255];
    always @(posedge clk) color_out <= mem[y_read][x_read];

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       vb;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   e     = 0;

    task automatic fill_mem();
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 256; x++)
                mem[y][x] = 3'($urandom);
    endtask

    // Expected outputs after edge number e since reset release, from raster arithmetic:
    // tick t registers the address of pixel t-1 and displays pixel t-2.
    function automatic exp_t model(input int edges);
        exp_t m;
        int   t, p, h, v;
        logic [2:0] c;
        bit   pix;
        m     = '0;
        m.hs  = 1'b1;
        m.vs  = 1'b1;
        t     = edges / CD;
        pix   = (edges > 0) && (edges % CD == 0);
        if (t >= 1) begin
            p = t - 1;
            h = p % HT;
            v = (p / HT) % VT;
            if (h < HV && v < VV) begin
                m.x = 8'(h >> SS);
                m.y = 7'(v >> SS);
            end
            m.fs = pix && (p % FT == FT - 1);
        end
        if (t >= 2) begin
            p    = t - 2;
            h    = p % HT;
            v    = (p / HT) % VT;
            m.hs = !(h >= HV + HF && h < HV + HF + HSY);
            m.vs = !(v >= VV + VF && v < VV + VF + VSY);
            if (h < HV && v < VV) begin
                c       = mem[v >> SS][h >> SS];
                m.blank = 1'b1;
                m.r     = {8{c[2]}};
                m.g     = {8{c[1]}};
                m.b     = {8{c[0]}};
            end
        end
        m.vb = (((t / HT) % VT) >= VV);
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, want);
        end
    endtask

    task automatic clk_step(input logic rst_after);
        @(posedge clk);
        if (reset) e = 0;
        else       e++;
        q.push_back(model(e));
        #1 reset = rst_after;
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                ex = q.pop_front();
                chk("x_read",      32'(x_read),      32'(ex.x));
                chk("y_read",      32'(y_read),      32'(ex.y));
                chk("rgb",         {8'h0, vga_r, vga_g, vga_b}, {8'h0, ex.r, ex.g, ex.b});
                chk("hs_vs_blank", {29'h0, vga_hs, vga_vs, vga_blank_n}, {29'h0, ex.hs, ex.vs, ex.blank});
                chk("frame_start", 32'(frame_start), 32'(ex.fs));
                chk("in_vblank",   32'(in_vblank),   32'(ex.vb));
                chk("sync_n",      32'(vga_sync_n),  32'h0);
            end
        end
    end

    initial begin : driver
        fill_mem();
        reset = 1'b1;
        clk_step(1'b1);
        clk_step(1'b1);
        clk_step(1'b0);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(300, 2400);
            repeat (n - 1) clk_step(1'b0);
            clk_step(1'b1);
            fill_mem();
            clk_step(1'b0);
        end
        repeat (2 * FT * CD + 400) clk_step(1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
